// File: rtl/sbox_word_scheduler.sv
// sbox_word_scheduler
//   Round-robin scheduler that shares one external S-box datapath between
//   requester A (round datapath) and requester B (key expansion). A granted
//   32-bit word is latched, pushed through the S-box one byte at a time
//   (LSB byte first), and the substituted word is returned on out_word with
//   a one-cycle done pulse to the owner.
//
// Parameters
//   NUM_BYTES  bytes per word (only 4 is supported)
//   SBOX_LAT   cycles from sbox_byte/sbox_inv to a valid sbox_res (0..3)
//
// Ports
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req_x, word_x, inv_x         job request, input word, inverse select
//   gnt_x                        x owns the S-box for the current job
//   done_x                       one-cycle pulse, x's result is on out_word
//   out_word                     shared result word, held until next DONE
//   sbox_byte, sbox_inv          byte/direction presented to the S-box
//   sbox_res                     S-box result
//   busy                         high from grant through the DONE cycle
//   rot_a, rot_b                 only when SBOX_ROTWORD_EN is defined: rotate
//                                the latched word left 8 bits (RotWord)
//
// Optional feature macro: SBOX_ROTWORD_EN
module sbox_word_scheduler #(
  parameter int NUM_BYTES = 4,
  parameter int SBOX_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [31:0] word_a,
  input  logic        inv_a,
  output logic        gnt_a,
  output logic        done_a,
  input  logic        req_b,
  input  logic [31:0] word_b,
  input  logic        inv_b,
  output logic        gnt_b,
  output logic        done_b,
`ifdef SBOX_ROTWORD_EN
  input  logic        rot_a,
  input  logic        rot_b,
`endif
  output logic [31:0] out_word,
  output logic [7:0]  sbox_byte,
  output logic        sbox_inv,
  input  logic [7:0]  sbox_res,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE
  } state_e;

  localparam logic [1:0] LAST_K = 2'(NUM_BYTES - 1);
  // Last WAIT count before capture; ISSUE itself is the first hold cycle.
  localparam logic [1:0] LAT_M1 = 2'(SBOX_LAT - 1);

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [31:0] res_q, res_d;
  logic [31:0] out_word_q, out_word_d;
  logic [7:0]  sbox_byte_q, sbox_byte_d;
  logic        inv_q, inv_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic        owner_b_q, owner_b_d;   // 1 = current job belongs to B
  logic        last_b_q, last_b_d;     // 1 = B was served last
  logic        gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic        done_a_q, done_a_d, done_b_q, done_b_d;

  logic        pick_b;
  logic [31:0] sel_word;
  logic        cap;
  logic [1:0]  k_nxt;

  // Arbitration: lone requester wins; on a tie the one not served last wins.
  always_comb begin
    pick_b   = req_b && (!req_a || !last_b_q);
    sel_word = pick_b ? word_b : word_a;
`ifdef SBOX_ROTWORD_EN
    if (pick_b ? rot_b : rot_a) sel_word = {sel_word[23:0], sel_word[31:24]};
`endif
  end

  assign k_nxt = k_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    res_d       = res_q;
    out_word_d  = out_word_q;
    sbox_byte_d = sbox_byte_q;
    inv_d       = inv_q;
    k_d         = k_q;
    wcnt_d      = wcnt_q;
    owner_b_d   = owner_b_q;
    last_b_d    = last_b_q;
    gnt_a_d     = gnt_a_q;
    gnt_b_d     = gnt_b_q;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;
    cap         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          owner_b_d   = pick_b;
          word_d      = sel_word;
          inv_d       = pick_b ? inv_b : inv_a;
          sbox_byte_d = sel_word[7:0];
          gnt_a_d     = !pick_b;
          gnt_b_d     = pick_b;
          k_d         = 2'd0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A zero-latency S-box answers in the issue cycle itself.
        if (SBOX_LAT == 0) begin
          cap = 1'b1;
        end else if (SBOX_LAT == 1) begin
          state_d = S_CAPTURE;
        end else begin
          wcnt_d  = 2'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == LAT_M1) state_d = S_CAPTURE;
        else                  wcnt_d  = wcnt_q + 2'd1;
      end
      S_CAPTURE: cap = 1'b1;
      S_DONE: begin
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        last_b_d = owner_b_q;
        k_d      = 2'd0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cap) begin
      res_d[{k_q, 3'b000} +: 8] = sbox_res;
      if (k_q == LAST_K) begin
        // Last byte goes straight into out_word so it updates only at DONE.
        out_word_d = {sbox_res, res_q[23:0]};
        done_a_d   = !owner_b_q;
        done_b_d   = owner_b_q;
        state_d    = S_DONE;
      end else begin
        k_d         = k_nxt;
        sbox_byte_d = word_q[{k_nxt, 3'b000} +: 8];
        state_d     = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      res_q       <= '0;
      out_word_q  <= '0;
      sbox_byte_q <= '0;
      inv_q       <= 1'b0;
      k_q         <= '0;
      wcnt_q      <= '0;
      owner_b_q   <= 1'b0;
      last_b_q    <= 1'b1;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      done_a_q    <= 1'b0;
      done_b_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      res_q       <= res_d;
      out_word_q  <= out_word_d;
      sbox_byte_q <= sbox_byte_d;
      inv_q       <= inv_d;
      k_q         <= k_d;
      wcnt_q      <= wcnt_d;
      owner_b_q   <= owner_b_d;
      last_b_q    <= last_b_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      done_a_q    <= done_a_d;
      done_b_q    <= done_b_d;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign done_a    = done_a_q;
  assign done_b    = done_b_q;
  assign busy      = gnt_a_q | gnt_b_q;
  assign out_word  = out_word_q;
  assign sbox_byte = sbox_byte_q;
  assign sbox_inv  = inv_q;

endmodule
